// File: rtl/mem_stage.sv
// MEM stage of a 64-bit RV64I pipeline: issues data-memory accesses,
// waits for the completion strobe, extracts load data and holds the
// MEM/WB pipeline register.
// Memory handshake: dmem_req stays high, with address/data/byte enables
// stable, until the cycle in which dmem_ack is seen; that cycle completes
// the access. dmem_ack is ignored whenever dmem_req is low.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ALUResult_M,
  input  logic [63:0] WriteData_M,
  input  logic [63:0] PCPlus4_M,
  input  logic [4:0]  Rd_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  Funct3_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        Stall_M,
  output logic [63:0] ALUResult_W,
  output logic [63:0] ReadData_W,
  output logic [63:0] PCPlus4_W,
  output logic [4:0]  Rd_W,
  output logic        RegWrite_W,
  output logic [1:0]  ResultSrc_W,
  output logic        MisalignErr_W,
  output logic        o_dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  w_off;
  logic        w_is_load;
  logic        w_mem_op;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_err;
  logic        w_go;
  logic        w_req;
  logic [7:0]  w_be;
  logic [63:0] w_wdata;
  logic [63:0] w_shifted;
  logic [63:0] w_load_data;

  logic [63:0] r_alu_w;
  logic [63:0] r_rdata_w;
  logic [63:0] r_pc4_w;
  logic [4:0]  r_rd_w;
  logic        r_regwrite_w;
  logic [1:0]  r_resultsrc_w;
  logic        r_misalign_w;

  assign w_off     = ALUResult_M[2:0];
  assign w_is_load = (ResultSrc_M == 2'b01) & ~MemWrite_M;
  assign w_mem_op  = MemWrite_M | (ResultSrc_M == 2'b01);
  // Funct3 111 has no load meaning in RV64I, so it is trapped like a misalignment.
  assign w_illegal = w_is_load & (Funct3_M == 3'b111);
  assign w_err     = w_mem_op & (w_misalign | w_illegal);
  assign w_go      = w_mem_op & ~w_err;

  // Request is gated by reset so the bus drops the instant reset asserts.
  assign w_req     = rst_n & (w_go | (r_state == ST_WAIT));

  assign dmem_req    = w_req;
  assign dmem_we     = w_req & MemWrite_M;
  assign Stall_M     = w_req & ~dmem_ack;
  assign dmem_addr   = rst_n ? {ALUResult_M[63:3], 3'b000} : 64'd0;
  assign dmem_be     = rst_n ? w_be : 8'd0;
  assign dmem_wdata  = rst_n ? w_wdata : 64'd0;
  assign o_dbg_state = r_state;

  // Alignment check, byte enables and lane-replicated store data by access size.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 8'd0;
    w_wdata    = 64'd0;
    case (Funct3_M[1:0])
      2'b00: begin
        w_be    = 8'h01 << w_off;
        w_wdata = {8{WriteData_M[7:0]}};
      end
      2'b01: begin
        w_misalign = w_off[0];
        w_be       = 8'h03 << w_off;
        w_wdata    = {4{WriteData_M[15:0]}};
      end
      2'b10: begin
        w_misalign = |w_off[1:0];
        w_be       = 8'h0F << w_off;
        w_wdata    = {2{WriteData_M[31:0]}};
      end
      default: begin
        w_misalign = |w_off;
        w_be       = 8'hFF;
        w_wdata    = WriteData_M;
      end
    endcase
  end

  assign w_shifted = dmem_rdata >> {w_off, 3'b000};

  // Pick the addressed field out of the doubleword and sign/zero extend it.
  always_comb begin
    w_load_data = 64'd0;
    case (Funct3_M)
      3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b011:  w_load_data = w_shifted;
      3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
      3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
      default: w_load_data = 64'd0;
    endcase
  end

  // Access FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: leave IDLE only when an access is not acked immediately.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go && !dmem_ack) w_state_next = ST_WAIT;
      ST_WAIT: if (dmem_ack)          w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_w       <= 64'd0;
      r_rdata_w     <= 64'd0;
      r_pc4_w       <= 64'd0;
      r_rd_w        <= 5'd0;
      r_regwrite_w  <= 1'b0;
      r_resultsrc_w <= 2'b00;
      r_misalign_w  <= 1'b0;
    end else if (Stall_M) begin
      r_alu_w       <= 64'd0;
      r_rdata_w     <= 64'd0;
      r_pc4_w       <= 64'd0;
      r_rd_w        <= 5'd0;
      r_regwrite_w  <= 1'b0;
      r_resultsrc_w <= 2'b00;
      r_misalign_w  <= 1'b0;
    end else begin
      r_alu_w       <= ALUResult_M;
      r_rdata_w     <= (w_is_load && !w_err) ? w_load_data : 64'd0;
      r_pc4_w       <= PCPlus4_M;
      r_rd_w        <= Rd_M;
      r_regwrite_w  <= RegWrite_M & ~w_err;
      r_resultsrc_w <= ResultSrc_M;
      r_misalign_w  <= w_err;
    end
  end

  assign ALUResult_W   = r_alu_w;
  assign ReadData_W    = r_rdata_w;
  assign PCPlus4_W     = r_pc4_w;
  assign Rd_W          = r_rd_w;
  assign RegWrite_W    = r_regwrite_w;
  assign ResultSrc_W   = r_resultsrc_w;
  assign MisalignErr_W = r_misalign_w;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus
// randomized instruction streams checked every cycle against a byte-level
// reference model of the MEM stage.
module tb_mem_stage;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_PC4 = 3;

  logic        clk;
  logic        rst_n;
  logic [63:0] ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  Rd_M;
  logic        RegWrite_M;
  logic [1:0]  ResultSrc_M;
  logic        MemWrite_M;
  logic [2:0]  Funct3_M;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic        Stall_M;
  logic [63:0] ALUResult_W, ReadData_W, PCPlus4_W;
  logic [4:0]  Rd_W;
  logic        RegWrite_W;
  logic [1:0]  ResultSrc_W;
  logic        MisalignErr_W;
  logic        o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
    .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
    .MemWrite_M(MemWrite_M), .Funct3_M(Funct3_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .Stall_M(Stall_M),
    .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W),
    .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
    .MisalignErr_W(MisalignErr_W), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_is_mem(input logic mw, input logic [1:0] rs);
    return mw || (rs == 2'b01);
  endfunction

  function automatic bit m_is_load(input logic mw, input logic [1:0] rs);
    return (rs == 2'b01) && !mw;
  endfunction

  function automatic bit m_err(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                               input logic [63:0] a);
    if (!m_is_mem(mw, rs)) return 1'b0;
    if (m_is_load(mw, rs) && f3 == 3'b111) return 1'b1;
    return (int'(a[2:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
    logic [63:0] v;
    int n;
    n = m_size(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*((off + i) % 8) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] f3, input int off);
    logic [7:0] be;
    be = '0;
    for (int i = 0; i < m_size(f3); i++) be[(off + i) % 8] = 1'b1;
    return be;
  endfunction

  // ---------------- compare process ----------------
  logic [63:0] e_alu, e_rdata, e_pc4;
  logic [4:0]  e_rd;
  logic        e_rw, e_err, e_bubble;
  logic [1:0]  e_rs;

  initial begin
    bit          go, err, stall;
    int          off;
    logic [7:0]  be;
    logic [63:0] mask, exp_wd;
    e_alu = '0; e_rdata = '0; e_pc4 = '0; e_rd = '0; e_rw = 0; e_err = 0; e_rs = '0; e_bubble = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", Stall_M, 0);
        chk("rst_alu_w", ALUResult_W, 0);
        chk("rst_rw_w", RegWrite_W, 0);
        chk("rst_err_w", MisalignErr_W, 0);
        e_alu = '0; e_rdata = '0; e_pc4 = '0; e_rd = '0; e_rw = 0; e_err = 0; e_rs = '0; e_bubble = 0;
        continue;
      end
      if (e_bubble) begin
        chk("bub_rw_w", RegWrite_W, 0);
        chk("bub_err_w", MisalignErr_W, 0);
        chk("bub_rd_w", Rd_W, 0);
      end else begin
        chk("alu_w", ALUResult_W, e_alu);
        chk("rdata_w", ReadData_W, e_rdata);
        chk("pc4_w", PCPlus4_W, e_pc4);
        chk("rd_w", Rd_W, e_rd);
        chk("rw_w", RegWrite_W, e_rw);
        chk("rs_w", ResultSrc_W, e_rs);
        chk("err_w", MisalignErr_W, e_err);
      end
      err   = m_err(MemWrite_M, ResultSrc_M, Funct3_M, ALUResult_M);
      go    = m_is_mem(MemWrite_M, ResultSrc_M) && !err;
      stall = go && !dmem_ack;
      off   = int'(ALUResult_M[2:0]);
      chk("req", dmem_req, go);
      chk("stall", Stall_M, stall);
      chk("we", dmem_we, go && MemWrite_M);
      if (go) chk("addr", dmem_addr, ALUResult_M & ~64'h7);
      if (go && MemWrite_M) begin
        be = m_be(Funct3_M, off);
        chk("be", dmem_be, be);
        mask = '0; exp_wd = '0;
        for (int i = 0; i < 8; i++)
          if (be[i]) begin
            mask[8*i +: 8]   = 8'hFF;
            exp_wd[8*i +: 8] = WriteData_M[8*(i - off) +: 8];
          end
        chk("wdata", dmem_wdata & mask, exp_wd);
      end
      e_bubble = stall;
      e_alu    = ALUResult_M;
      e_pc4    = PCPlus4_M;
      e_rd     = Rd_M;
      e_rs     = ResultSrc_M;
      e_err    = err;
      e_rw     = RegWrite_M && !err;
      e_rdata  = (go && m_is_load(MemWrite_M, ResultSrc_M)) ? m_load(dmem_rdata, Funct3_M, off) : 64'd0;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the instruction retires.
  task automatic issue(input int kind, input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] pc4, input logic [4:0] rd, input logic rw,
                       input logic [2:0] f3, input logic [63:0] rdata, input int lat,
                       output int stalls, output logic req0, output logic we0,
                       output logic [7:0] be0, output logic [63:0] wd0);
    bit go;
    ALUResult_M = a; WriteData_M = wd; PCPlus4_M = pc4; Rd_M = rd; RegWrite_M = rw;
    Funct3_M = f3; dmem_rdata = rdata;
    case (kind)
      K_ALU:   begin ResultSrc_M = 2'b00; MemWrite_M = 1'b0; end
      K_LD:    begin ResultSrc_M = 2'b01; MemWrite_M = 1'b0; end
      K_ST:    begin ResultSrc_M = 2'b00; MemWrite_M = 1'b1; end
      default: begin ResultSrc_M = 2'b10; MemWrite_M = 1'b0; end
    endcase
    go = m_is_mem(MemWrite_M, ResultSrc_M) && !m_err(MemWrite_M, ResultSrc_M, f3, a);
    stalls = 0;
    req0 = 0; we0 = 0; be0 = '0; wd0 = '0;
    for (int c = 0; c <= lat; c++) begin
      if (go) dmem_ack = (c == lat);
      else    dmem_ack = 1'($urandom_range(0, 1));
      #1;
      if (c == 0) begin req0 = dmem_req; we0 = dmem_we; be0 = dmem_be; wd0 = dmem_wdata; end
      if (Stall_M) stalls++;
      @(posedge clk); #1;
      if (!go) break;
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    int          s;
    logic        rq, we;
    logic [7:0]  be;
    logic [63:0] wdv;
    int          kind;
    logic [2:0]  f3;

    rst_n = 1'b0;
    ALUResult_M = '0; WriteData_M = '0; PCPlus4_M = '0; Rd_M = '0; RegWrite_M = 0;
    ResultSrc_M = '0; MemWrite_M = 0; Funct3_M = '0; dmem_rdata = '0; dmem_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_alu_w", ALUResult_W, 0);
    chk("reset_rw_w", RegWrite_W, 0);
    chk("reset_req", dmem_req, 0);
    rst_n = 1'b1;

    // ALU pass-through
    issue(K_ALU, 64'hAAAA_AAAA_AAAA_AAAA, 0, 64'h100, 5'd7, 1, 3'b000, 0, 0, s, rq, we, be, wdv);
    chk("alu_req", rq, 0);
    chk("alu_result", ALUResult_W, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("alu_rw", RegWrite_W, 1);
    chk("alu_rd", Rd_W, 7);

    // LB zero-wait, sign-extended
    issue(K_LD, 64'h1003, 0, 64'h204, 5'd5, 1, 3'b000, 64'h0000_0000_8000_0000, 0, s, rq, we, be, wdv);
    chk("lb_data", ReadData_W, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_stalls", s, 0);
    chk("lb_rw", RegWrite_W, 1);

    // LWU with 3 wait cycles
    issue(K_LD, 64'h1004, 0, 64'h208, 5'd6, 1, 3'b110, 64'hDEAD_BEEF_0123_4567, 3, s, rq, we, be, wdv);
    chk("lwu_stalls", s, 3);
    chk("lwu_data", ReadData_W, 64'h0000_0000_DEAD_BEEF);

    // SH to upper halfword lane
    issue(K_ST, 64'h2006, 64'h1234, 64'h20C, 5'd0, 0, 3'b001, 0, 0, s, rq, we, be, wdv);
    chk("sh_be", be, 8'hC0);
    chk("sh_wdata_hi", wdv[63:48], 16'h1234);
    chk("sh_we", we, 1);
    chk("sh_rw", RegWrite_W, 0);

    // Misaligned LD
    issue(K_LD, 64'h2004, 0, 64'h210, 5'd9, 1, 3'b011, 64'h55, 0, s, rq, we, be, wdv);
    chk("ld_mis_req", rq, 0);
    chk("ld_mis_err", MisalignErr_W, 1);
    chk("ld_mis_rw", RegWrite_W, 0);
    chk("ld_mis_rd", Rd_W, 9);
    issue(K_ALU, 64'h42, 0, 64'h214, 5'd3, 1, 3'b000, 0, 0, s, rq, we, be, wdv);
    chk("ld_mis_err_clr", MisalignErr_W, 0);

    // Illegal funct3 on a load
    issue(K_LD, 64'h2000, 0, 64'h218, 5'd4, 1, 3'b111, 0, 0, s, rq, we, be, wdv);
    chk("ill_req", rq, 0);
    chk("ill_err", MisalignErr_W, 1);

    // Reset asserted while waiting
    ALUResult_M = 64'h3000; ResultSrc_M = 2'b01; MemWrite_M = 0; Funct3_M = 3'b010;
    Rd_M = 5'd11; RegWrite_M = 1; PCPlus4_M = 64'h300; dmem_ack = 0;
    @(posedge clk); #1;
    chk("wait_stall", Stall_M, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_stall", Stall_M, 0);
    chk("arst_pc4_w", PCPlus4_W, 0);
    chk("arst_rdata_w", ReadData_W, 0);
    ResultSrc_M = 2'b00; RegWrite_M = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", dmem_req, 0);
    chk("post_rst_stall", Stall_M, 0);
    @(posedge clk); #1;
    issue(K_LD, 64'h3000, 0, 64'h304, 5'd12, 1, 3'b011, 64'h0123_4567_89AB_CDEF, 1, s, rq, we, be, wdv);
    chk("post_rst_ld", ReadData_W, 64'h0123_4567_89AB_CDEF);

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == K_ST) f3 = 3'($urandom_range(0, 3));
      else              f3 = 3'($urandom_range(0, 7));
      issue(kind, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), f3,
            {$urandom, $urandom}, $urandom_range(0, 3), s, rq, we, be, wdv);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
